// File: rtl/demux32_1to2_buf_pkg.sv
// Shared definitions for the registered 1-to-2 word demultiplexer.
//   DEMUX_SEL_A / DEMUX_SEL_B : encodings of the sel input.
//   ch_state_t                : per-channel buffer state (CH_EMPTY, CH_FULL).
//   DEMUX_DEFAULT_WIDTH       : default data word width.
package demux32_1to2_buf_pkg;

    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

    localparam int unsigned DEMUX_DEFAULT_WIDTH = 32;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/demux32_1to2_buf_chan_buf.sv
// demux_chan_buf: one-entry output holding buffer for one demux channel.
// Ports:
//   Clk, Rst_n   : clock, asynchronous active-low reset.
//   load         : a word for this channel is accepted this cycle.
//   load_data    : the word being accepted.
//   ready        : downstream consumer takes the held word this cycle.
//   valid        : buffer holds a word (state FULL).
//   data         : held word; retains the last value while EMPTY.
//   can_accept   : buffer can take a word this cycle (EMPTY, or FULL and draining).
module demux_chan_buf
    import demux32_1to2_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    ch_state_t state_q;
    ch_state_t state_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= CH_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CH_EMPTY: begin
                if (load) state_d = CH_FULL;
            end
            CH_FULL: begin
                // A load while full is only possible when ready is high, so
                // this covers both hold and simultaneous drain/refill.
                if (load)       state_d = CH_FULL;
                else if (ready) state_d = CH_EMPTY;
            end
            default: state_d = CH_EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    assign valid      = (state_q == CH_FULL);
    assign can_accept = (state_q == CH_EMPTY) || ready;

endmodule

// File: rtl/demux32_1to2_buf.sv
// demux32_1to2_buf: registered 1-to-2 demultiplexer with valid/ready on the
// input and on each output. Each accepted word is routed by sel into a
// one-entry buffer for channel A (sel = 0) or channel B (sel = 1).
// Ports:
//   Clk, Rst_n                         : clock, asynchronous active-low reset.
//   in_valid, in_ready, in_data, sel   : producer side.
//   outA_valid, outA_ready, outA_data  : consumer A.
//   outB_valid, outB_ready, outB_data  : consumer B.
//   cntA, cntB                         : 16-bit wrapping counts of completed
//                                        output transfers; present only when
//                                        DEMUX32_STATS_EN is defined.
module demux32_1to2_buf
    import demux32_1to2_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    output logic             outA_valid,
    input  logic             outA_ready,
    output logic [WIDTH-1:0] outA_data,
    output logic             outB_valid,
    input  logic             outB_ready,
    output logic [WIDTH-1:0] outB_data
`ifdef DEMUX32_STATS_EN
    ,
    output logic [15:0]      cntA,
    output logic [15:0]      cntB
`endif
);

    logic sel_a;
    logic can_a;
    logic can_b;
    logic accept;
    logic load_a;
    logic load_b;

    assign sel_a = (sel == DEMUX_SEL_A);

    // Only the selected channel gates the input; Rst_n forces in_ready low
    // while reset is asserted.
    assign in_ready = Rst_n && (sel_a ? can_a : can_b);
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && sel_a;
    assign load_b   = accept && !sel_a;

    demux_chan_buf #(
        .WIDTH(WIDTH)
    ) u_chan_a (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .load       (load_a),
        .load_data  (in_data),
        .ready      (outA_ready),
        .valid      (outA_valid),
        .data       (outA_data),
        .can_accept (can_a)
    );

    demux_chan_buf #(
        .WIDTH(WIDTH)
    ) u_chan_b (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .load       (load_b),
        .load_data  (in_data),
        .ready      (outB_ready),
        .valid      (outB_valid),
        .data       (outB_data),
        .can_accept (can_b)
    );

`ifdef DEMUX32_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cntA <= '0;
            cntB <= '0;
        end else begin
            if (outA_valid && outA_ready) cntA <= cntA + 16'd1;
            if (outB_valid && outB_ready) cntB <= cntB + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux32_1to2_buf.sv
// Directed testbench for demux32_1to2_buf. Build with DEMUX32_STATS_EN
// defined to also exercise the transfer counters.
module tb_demux32_1to2_buf;

    localparam int unsigned WIDTH = 32;

    logic             Clk;
    logic             Rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             outA_valid;
    logic             outA_ready;
    logic [WIDTH-1:0] outA_data;
    logic             outB_valid;
    logic             outB_ready;
    logic [WIDTH-1:0] outB_data;
`ifdef DEMUX32_STATS_EN
    logic [15:0]      cntA;
    logic [15:0]      cntB;
`endif

    int unsigned checks;
    int unsigned errors;

    demux32_1to2_buf #(
        .WIDTH(WIDTH)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sel        (sel),
        .outA_valid (outA_valid),
        .outA_ready (outA_ready),
        .outA_data  (outA_data),
        .outB_valid (outB_valid),
        .outB_ready (outB_ready),
        .outB_data  (outB_data)
`ifdef DEMUX32_STATS_EN
        ,
        .cntA       (cntA),
        .cntB       (cntB)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Producer protocol: while a word is offered but stalled, sel and
    // in_data must stay stable until the transfer.
    logic             prev_stall;
    logic             prev_sel;
    logic [WIDTH-1:0] prev_data;
    initial prev_stall = 1'b0;
    always @(posedge Clk) begin
        if (Rst_n && prev_stall && in_valid) begin
            assert (sel == prev_sel && in_data == prev_data)
                else $error("producer changed sel/in_data while stalled");
        end
        prev_stall <= Rst_n && in_valid && !in_ready;
        prev_sel   <= sel;
        prev_data  <= in_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        Rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        sel        = 1'b0;
        outA_ready = 1'b1;
        outB_ready = 1'b1;

        // Reset then idle
        #1 Rst_n = 1'b0;
        step();
        step();
        check_eq("rst_a_valid", {31'b0, outA_valid}, 32'd0);
        check_eq("rst_b_valid", {31'b0, outB_valid}, 32'd0);
        check_eq("rst_a_data",  outA_data, 32'h0);
        check_eq("rst_b_data",  outB_data, 32'h0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef DEMUX32_STATS_EN
        check_eq("rst_cntA", {16'b0, cntA}, 32'd0);
        check_eq("rst_cntB", {16'b0, cntB}, 32'd0);
`endif
        Rst_n = 1'b1;
        #1;
        check_eq("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Single routed word to A
        in_data  = 32'hDEADBEEF;
        sel      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check_eq("single_a_valid", {31'b0, outA_valid}, 32'd1);
        check_eq("single_a_data",  outA_data, 32'hDEADBEEF);
        check_eq("single_b_valid", {31'b0, outB_valid}, 32'd0);
        step();
        check_eq("single_a_drain", {31'b0, outA_valid}, 32'd0);

        // Stall isolation
        outA_ready = 1'b0;
        in_data    = 32'h11111111;
        sel        = 1'b0;
        in_valid   = 1'b1;
        step();
        check_eq("stall_a_valid", {31'b0, outA_valid}, 32'd1);
        check_eq("stall_a_data",  outA_data, 32'h11111111);
        in_data = 32'h33333333;
        #1;
        check_eq("stall_in_ready_a", {31'b0, in_ready}, 32'd0);
        step();
        check_eq("stall_a_hold", outA_data, 32'h11111111);
        in_valid = 1'b0;
        step();
        sel      = 1'b1;
        in_data  = 32'h22222222;
        in_valid = 1'b1;
        #1;
        check_eq("stall_in_ready_b", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("stall_b_valid", {31'b0, outB_valid}, 32'd1);
        check_eq("stall_b_data",  outB_data, 32'h22222222);
        check_eq("stall_a_still", outA_data, 32'h11111111);
        check_eq("stall_a_still_valid", {31'b0, outA_valid}, 32'd1);

        // Both full and stalled: in_ready low for either sel
        outB_ready = 1'b0;
        sel = 1'b0;
        #1;
        check_eq("both_full_sel0", {31'b0, in_ready}, 32'd0);
        sel = 1'b1;
        #1;
        check_eq("both_full_sel1", {31'b0, in_ready}, 32'd0);

        // Simultaneous drain and refill on A
        outA_ready = 1'b1;
        sel        = 1'b0;
        #1;
        check_eq("full_ready_in_ready", {31'b0, in_ready}, 32'd1);
        in_data  = 32'h44444444;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check_eq("refill_a_valid", {31'b0, outA_valid}, 32'd1);
        check_eq("refill_a_data",  outA_data, 32'h44444444);
        step();
        check_eq("refill_a_drain", {31'b0, outA_valid}, 32'd0);
        check_eq("b_held_valid",   {31'b0, outB_valid}, 32'd1);

        // Back-to-back streaming on A
        sel = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            in_data  = i;
            in_valid = 1'b1;
            #1;
            check_eq($sformatf("stream_ready_%0d", i), {31'b0, in_ready}, 32'd1);
            step();
            check_eq($sformatf("stream_valid_%0d", i), {31'b0, outA_valid}, 32'd1);
            check_eq($sformatf("stream_data_%0d", i), outA_data, i);
        end
        in_valid = 1'b0;
        step();
        check_eq("stream_end_a", {31'b0, outA_valid}, 32'd0);
        outB_ready = 1'b1;
        step();
        check_eq("b_drain", {31'b0, outB_valid}, 32'd0);

        // Async reset mid-operation
        outA_ready = 1'b0;
        outB_ready = 1'b0;
        sel        = 1'b0;
        in_data    = 32'hA5A5A5A5;
        in_valid   = 1'b1;
        step();
        sel     = 1'b1;
        in_data = 32'h5A5A5A5A;
        step();
        in_valid = 1'b0;
        #1;
        check_eq("pre_rst_a_valid", {31'b0, outA_valid}, 32'd1);
        check_eq("pre_rst_b_valid", {31'b0, outB_valid}, 32'd1);
        check_eq("pre_rst_b_data",  outB_data, 32'h5A5A5A5A);
        Rst_n = 1'b0;
        #1;
        check_eq("async_a_valid", {31'b0, outA_valid}, 32'd0);
        check_eq("async_b_valid", {31'b0, outB_valid}, 32'd0);
        check_eq("async_a_data",  outA_data, 32'h0);
        check_eq("async_b_data",  outB_data, 32'h0);
        check_eq("async_in_ready", {31'b0, in_ready}, 32'd0);
        Rst_n = 1'b1;
        sel   = 1'b0;
        #1;
        check_eq("post_rst_ready_a", {31'b0, in_ready}, 32'd1);
        sel = 1'b1;
        #1;
        check_eq("post_rst_ready_b", {31'b0, in_ready}, 32'd1);
        step();
        check_eq("post_rst_a_valid", {31'b0, outA_valid}, 32'd0);
        check_eq("post_rst_b_valid", {31'b0, outB_valid}, 32'd0);

`ifdef DEMUX32_STATS_EN
        // 0x10000 transfers on A wrap cntA back to zero
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        sel        = 1'b0;
        in_valid   = 1'b1;
        for (int unsigned i = 0; i < 32'h10000; i++) begin
            in_data = i;
            step();
        end
        in_valid = 1'b0;
        step();
        check_eq("stats_cntA_wrap", {16'b0, cntA}, 32'd0);
        check_eq("stats_cntB", {16'b0, cntB}, 32'd0);
        // One more transfer on each channel
        in_valid = 1'b1;
        in_data  = 32'h1;
        step();
        sel = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("stats_cntA_one", {16'b0, cntA}, 32'd1);
        check_eq("stats_cntB_one", {16'b0, cntB}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux32_1to2_buf.md
Name: demux32_1to2_buf

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake on the input and on each output.
- Routes each accepted input word to output A or output B according to `sel`.
- Pipeline-side counterpart of the 2-to-1 word select: one producer, two consumers. Example use: an EX/MEM result steered to write-back or to the store path.
- Each output channel has a one-entry holding buffer, so a stalled consumer never corrupts or drops data.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  input word.
- sel  input  1  destination select, sampled with in_data; 0 = channel A, 1 = channel B.
- outA_valid  output  1  channel A buffer holds a word.
- outA_ready  input  1  consumer A takes the word this cycle.
- outA_data  output  WIDTH  channel A word.
- outB_valid  output  1  channel B buffer holds a word.
- outB_ready  input  1  consumer B takes the word this cycle.
- outB_data  output  WIDTH  channel B word.

Behaviour:
- Reset:
  - Clk is the single clock. Rst_n is asynchronous and active-low.
  - While Rst_n = 0: outA_valid = outB_valid = 0 and outA_data = outB_data = 0, effective immediately without waiting for a clock edge.
  - in_ready = 0 while Rst_n = 0.
  - A word held when reset asserts is discarded.
  - Reset deassertion is synchronized externally; the first accept can occur on the first edge after deassertion.
- Channel state machine (one per channel):
  - States: EMPTY, FULL. outX_valid = 1 exactly in FULL.
  - EMPTY -> FULL: input accepted with sel selecting X.
  - FULL -> EMPTY: outX_ready = 1 and no new word for X accepted that cycle.
  - FULL -> FULL with new data: outX_ready = 1 and a new word for X accepted in the same cycle (simultaneous drain and refill).
  - FULL, outX_ready = 0: hold state; outX_data stays stable.
- Input handshake:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = (selected channel EMPTY) || (selected channel FULL && its outX_ready). Combinational in sel, the buffer state and the selected channel's outX_ready.
  - in_ready never depends on in_valid.
  - The non-selected channel never blocks the input: A full and stalled does not prevent a sel = 1 transfer into B.
- Latency: one cycle from accept to outX_valid.
- Throughput: one word per cycle per channel when the consumer is always ready.
- Data path:
  - outX_data is loaded only on accept into X.
  - While EMPTY, outX_data retains the last delivered value. Benches must ignore it.
  - No width conversion; data passes bit-exact.
- Ordering:
  - Order is preserved within each channel.
  - No ordering guarantee between channels.
- Boundaries:
  - Both channels FULL and stalled: in_ready = 0 for either sel.
  - in_valid = 1 with in_ready = 0: producer must hold in_data and sel stable until the transfer.
  - sel changing while in_valid is held stable but stalled is a producer protocol violation. Behaviour is undefined; a bench assertion flags it.

Optional Feature:
- Macro: DEMUX32_STATS_EN.
- When defined:
  - Adds output ports cntA and cntB, each 16 bits: count of completed output transfers (outX_valid && outX_ready) per channel.
  - Counters wrap from 0xFFFF to 0x0000.
  - Reset to 0 asynchronously with Rst_n.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - DEMUX_SEL_A = 1'b0, DEMUX_SEL_B = 1'b1.
  - Channel state encodings CH_EMPTY = 1'b0, CH_FULL = 1'b1.
  - Default word width 32.
- One sub-module, demux_chan_buf:
  - One-entry buffer with load, drain, valid and data; parameterized by WIDTH.
  - Instantiated twice.
  - Reports its "can accept" term (EMPTY || ready) to the top level for in_ready.
- The top level contains only the sel decode, the in_ready mux and the optional counters.

Test Plan:
- Reset then idle: Rst_n = 0 -> all valid = 0, data = 0, in_ready = 0. Release -> in_ready = 1 with both ready = 1.
- Single routed word: in_data = 0xDEADBEEF, sel = 0, in_valid one cycle -> outA_valid = 1, outA_data = 0xDEADBEEF next cycle; outB_valid stays 0.
- Stall isolation: outA_ready = 0, A loaded with 0x11111111. Further sel = 0 word -> in_ready = 0. Then sel = 1, 0x22222222 -> accepted, outB_data = 0x22222222; outA_data still 0x11111111.
- Back-to-back streaming: outA_ready = 1, words 1..8 with sel = 0 each cycle -> in_ready = 1 throughout; outA_data = 1..8 on consecutive cycles.
- Async reset mid-operation: both channels FULL, Rst_n pulsed low between edges -> valid outputs drop immediately; after release both channels EMPTY.
- DEMUX32_STATS_EN: 0x10000 transfers on A -> cntA = 0x0000 (wrapped), cntB = 0.
